// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues word fetches under a credit limit, buffers responses with
// their PCs in an in-order FIFO, and flushes/drops stale responses on a redirect.
module instr_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [7:0]      stall_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
    state_t state_reg, state_next;

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [CW-1:0]   fifo_cnt_reg, fifo_cnt_next;
    logic [CW-1:0]   out_cnt_reg, out_cnt_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [7:0]      stall_cnt_reg, stall_cnt_next;
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];

    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [CW:0]   occupancy;
    logic [XLEN-1:0] target_pc;

    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};
    // Outstanding requests reserve FIFO slots so a response can always be pushed.
    assign occupancy = {1'b0, fifo_cnt_reg} + {1'b0, out_cnt_reg};
    assign credit_ok = (out_cnt_reg < MAX_OUT_C) && (occupancy < {1'b0, DEPTH_C});

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = (out_cnt_next != '0) ? FLUSH : RUN;
        end else if (state_reg == FLUSH && drop_cnt_next == '0) begin
            state_next = RUN;
        end
    end

    // FSM: outputs
    always_comb begin
        imem_req   = rst_n && (state_reg == RUN) && !redirect_valid && credit_ok;
        inst_valid = rst_n && (state_reg == RUN) && (fifo_cnt_reg != '0);
    end

    assign imem_addr = fetch_pc_reg;
    assign inst_data = data_mem[rd_ptr_reg];
    assign inst_pc   = pc_mem[rd_ptr_reg];
    assign stall_cnt = stall_cnt_reg;

    // A response in the redirect cycle belongs to the old stream, so it is dropped too.
    always_comb begin
        accept = imem_req && imem_ready;
        drop   = imem_rvalid && ((drop_cnt_reg != '0) || redirect_valid);
        push   = imem_rvalid && !drop;
        pop    = inst_valid && inst_ready && !redirect_valid;
    end

    always_comb begin
        out_cnt_next   = out_cnt_reg + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, imem_rvalid};
        drop_cnt_next  = drop_cnt_reg;
        fetch_pc_next  = fetch_pc_reg;
        resp_pc_next   = resp_pc_reg;
        fifo_cnt_next  = fifo_cnt_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        stall_cnt_next = stall_cnt_reg;

        if (imem_rvalid && drop_cnt_reg != '0) begin
            drop_cnt_next = drop_cnt_reg - {{(CW-1){1'b0}}, 1'b1};
        end
        if (accept) begin
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
        end
        if (push) begin
            resp_pc_next = resp_pc_reg + XLEN'(4);
            wr_ptr_next  = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        fifo_cnt_next = fifo_cnt_reg + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

        if (redirect_valid) begin
            fetch_pc_next = target_pc;
            resp_pc_next  = target_pc;
            drop_cnt_next = out_cnt_next;
            fifo_cnt_next = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end

        if (state_reg == RUN && !inst_valid && stall_cnt_reg != 8'hFF) begin
            stall_cnt_next = stall_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_reg  <= RESET_PC;
            resp_pc_reg   <= RESET_PC;
            fifo_cnt_reg  <= '0;
            out_cnt_reg   <= '0;
            drop_cnt_reg  <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            fetch_pc_reg  <= fetch_pc_next;
            resp_pc_reg   <= resp_pc_next;
            fifo_cnt_reg  <= fifo_cnt_next;
            out_cnt_reg   <= out_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Entry storage carries no reset; the counters alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= resp_pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (fifo_cnt_reg <= DEPTH_C);
            assert (out_cnt_reg <= MAX_OUT_C);
            assert (drop_cnt_reg <= out_cnt_reg);
            assert (!(imem_rvalid && out_cnt_reg == '0));
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: an in-order memory model plus a scoreboard of the
// instruction stream decode should see, restarted at every redirect target.
module tb_instr_fetch_queue;
    localparam int XLEN     = 32;
    localparam int DEPTH    = 4;
    localparam int MAX_OUT  = 2;
    localparam int NCYC     = 4000;
    localparam int RST_CYC  = 2500;
    localparam int WRAP_CYC = 1800;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic [7:0]      stall_cnt;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .stall_cnt(stall_cnt)
    );

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } inst_t;

    mreq_t mem_q[$];
    inst_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    epoch = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Driver + memory model + cycle-level expectations
    initial begin
        int          stale;
        int          out_now;
        int          lat;
        int          avail;
        int          stall_exp;
        int          resp_ep;
        bit          flush;
        bit          exp_req;
        bit          exp_valid;
        bit          acc;
        bit          pp;
        bit          psh;
        logic [31:0] fpc;
        avail = 0;
        stall_exp = 0;
        fpc = 32'h0;
        lat = 1;
        for (int c = 1; c <= NCYC; c++) begin
            @(negedge clk);
            cyc = c;
            rst_n = !(c <= 3 || c == RST_CYC);
            if (c < 60) begin
                imem_ready     = 1'b1;
                inst_ready     = (c < 40);
                redirect_valid = 1'b0;
                lat            = 1;
            end else begin
                imem_ready     = ($urandom_range(0, 3) != 0);
                inst_ready     = ($urandom_range(0, 4) > 1);
                lat            = $urandom_range(1, 3);
                redirect_valid = (c == WRAP_CYC) || ($urandom_range(0, 15) == 0);
                if (c == WRAP_CYC)
                    redirect_pc = 32'hFFFF_FFFE;
                else if ($urandom_range(0, 3) == 0)
                    redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                else
                    redirect_pc = $urandom;
                if (c >= RST_CYC - 20 && c < RST_CYC) begin
                    inst_ready     = 1'b0;
                    redirect_valid = 1'b0;
                end
            end

            stale = 0;
            foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
            flush   = (stale != 0);
            out_now = mem_q.size();
            imem_rvalid = 1'b0;
            resp_ep = -1;
            if (rst_n && mem_q.size() > 0 && mem_q[0].due <= c) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_q[0].addr);
                resp_ep     = mem_q[0].epoch;
                void'(mem_q.pop_front());
            end else begin
                imem_rdata = $urandom;
            end

            exp_req   = rst_n && !flush && !redirect_valid && out_now < MAX_OUT && avail + out_now < DEPTH;
            exp_valid = rst_n && !flush && avail > 0;
            #1;
            check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
            if (exp_req) check("imem_addr", imem_addr, fpc);
            if (rst_n) check("stall_cnt", {24'b0, stall_cnt}, stall_exp);

            if (!rst_n) begin
                mem_q.delete();
                exp_q.delete();
                avail = 0;
                stall_exp = 0;
                fpc = 32'h0;
                epoch++;
            end else begin
                if (!flush && avail == 0 && stall_exp < 255) stall_exp++;
                acc = exp_req && imem_ready;
                pp  = exp_valid && inst_ready && !redirect_valid;
                psh = imem_rvalid && (resp_ep == epoch) && !redirect_valid;
                if (acc) begin
                    mem_q.push_back('{fpc, c + lat, epoch});
                    exp_q.push_back('{mem_word(fpc), fpc});
                    fpc = fpc + 32'd4;
                end
                avail = avail + int'(psh) - int'(pp);
                if (redirect_valid) begin
                    epoch++;
                    avail = 0;
                    fpc = {redirect_pc[31:2], 2'b00};
                    exp_q.delete();
                    $display("[TB] cycle %0d redirect to %h", c, redirect_pc);
                end
            end
        end
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Monitor: every instruction handed to decode must match the scoreboard head
    always @(negedge clk) begin
        inst_t e;
        #2;
        if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected cycle %0d: got pc %h with no expected entry", cyc, inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_data", inst_data, e.data);
                $display("[TB] cycle %0d pop pc=%h data=%h", cyc, inst_pc, inst_data);
            end
        end
    end

endmodule
